// File: rtl/lsu_pkg.sv
// Shared encodings for the memory-stage load/store unit: funct3 access
// sizes, exception cause codes and the bus FSM state type.
package lsu_pkg;

  localparam logic [2:0] LSU_OP_B  = 3'b000;
  localparam logic [2:0] LSU_OP_H  = 3'b001;
  localparam logic [2:0] LSU_OP_W  = 3'b010;
  localparam logic [2:0] LSU_OP_BU = 3'b100;
  localparam logic [2:0] LSU_OP_HU = 3'b101;

  localparam logic [4:0] CAUSE_LD_MISALIGN = 5'd4;
  localparam logic [4:0] CAUSE_LD_FAULT    = 5'd5;
  localparam logic [4:0] CAUSE_ST_MISALIGN = 5'd6;
  localparam logic [4:0] CAUSE_ST_FAULT    = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } lsu_state_t;

  // funct3[1:0] alone gives the size; illegal encodings fall into the word case
  function automatic logic lsu_misaligned(input logic [2:0] op, input logic [1:0] lsb);
    case (op[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lsb[0];
      default: return (lsb != 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte-enables/replication on the way out,
// load byte/half selection and sign/zero extension on the way back.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [1:0]  st_size,
  input  logic [1:0]  st_lsb,
  input  logic [31:0] st_data,
  output logic [3:0]  st_be,
  output logic [31:0] st_wdata,
  input  logic [2:0]  ld_op,
  input  logic [1:0]  ld_lsb,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_be    = 4'b1111;
    st_wdata = st_data;
    case (st_size)
      2'b00: begin
        st_be    = 4'b0001 << st_lsb;
        st_wdata = {4{st_data[7:0]}};
      end
      2'b01: begin
        st_be    = st_lsb[1] ? 4'b1100 : 4'b0011;
        st_wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_rdata[7:0];
    case (ld_lsb)
      2'b01:   ld_byte = ld_rdata[15:8];
      2'b10:   ld_byte = ld_rdata[23:16];
      2'b11:   ld_byte = ld_rdata[31:24];
      default: ;
    endcase
    ld_half = ld_lsb[1] ? ld_rdata[31:16] : ld_rdata[15:0];

    // funct3[2] marks the unsigned variants
    ld_data = ld_rdata;
    case (ld_op[1:0])
      2'b00:   ld_data = ld_op[2] ? {24'd0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = ld_op[2] ? {16'd0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: issues one data-bus transaction at a time,
// stalls the pipeline while it is in flight and reports write-back/exceptions.
module mem_lsu
  import lsu_pkg::*;
(
  input  logic        clk,
  input  logic        cpurst_n,
  input  logic        mem_en,
  input  logic        mem_wr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [2:0]  mem_op,
  input  logic [4:0]  mem_rd,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_gnt,
  input  logic        dbus_rvalid,
  input  logic [31:0] dbus_rdata,
  input  logic        dbus_err,
  output logic        mem_stall,
  output logic        lsu_wb_valid,
  output logic [4:0]  lsu_wb_rd,
  output logic [31:0] lsu_wb_data,
  output logic        lsu_exp,
  output logic [4:0]  lsu_causecode,
  output logic [31:0] lsu_mtval
);

  lsu_state_t  state, state_nxt;
  logic        req_we;
  logic [31:0] req_addr;
  logic [2:0]  req_op;
  logic [4:0]  req_rd;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;
  logic        misaligned;
  logic        accept;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;

  assign misaligned = lsu_misaligned(mem_op, mem_addr[1:0]);
  assign accept     = (state == ST_IDLE) && mem_en && !misaligned;

  lsu_align u_align (
    .st_size  (mem_op[1:0]),
    .st_lsb   (mem_addr[1:0]),
    .st_data  (mem_wdata),
    .st_be    (st_be),
    .st_wdata (st_wdata),
    .ld_op    (req_op),
    .ld_lsb   (req_addr[1:0]),
    .ld_rdata (dbus_rdata),
    .ld_data  (ld_data)
  );

  // Request is decoded from state so reset removes it without waiting for a clock
  assign dbus_req   = (state == ST_REQ);
  assign dbus_we    = req_we;
  assign dbus_addr  = {req_addr[31:2], 2'b00};
  assign dbus_be    = req_be;
  assign dbus_wdata = req_wdata;
  assign mem_stall  = accept || (state == ST_REQ) || ((state == ST_WAIT) && !dbus_rvalid);

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) state <= ST_IDLE;
    else           state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept)      state_nxt = ST_REQ;
      ST_REQ:  if (dbus_gnt)    state_nxt = ST_WAIT;
      ST_WAIT: if (dbus_rvalid) state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge cpurst_n) begin
    if (!cpurst_n) begin
      req_we        <= 1'b0;
      req_addr      <= '0;
      req_op        <= '0;
      req_rd        <= '0;
      req_be        <= '0;
      req_wdata     <= '0;
      lsu_wb_valid  <= 1'b0;
      lsu_wb_rd     <= '0;
      lsu_wb_data   <= '0;
      lsu_exp       <= 1'b0;
      lsu_causecode <= '0;
      lsu_mtval     <= '0;
    end else begin
      lsu_wb_valid <= 1'b0;
      lsu_exp      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_en && misaligned) begin
            lsu_exp       <= 1'b1;
            lsu_causecode <= mem_wr ? CAUSE_ST_MISALIGN : CAUSE_LD_MISALIGN;
            lsu_mtval     <= mem_addr;
          end else if (accept) begin
            req_we    <= mem_wr;
            req_addr  <= mem_addr;
            req_op    <= mem_op;
            req_rd    <= mem_rd;
            req_be    <= st_be;
            req_wdata <= st_wdata;
          end
        end
        ST_WAIT: begin
          if (dbus_rvalid) begin
            if (dbus_err) begin
              lsu_exp       <= 1'b1;
              lsu_causecode <= req_we ? CAUSE_ST_FAULT : CAUSE_LD_FAULT;
              lsu_mtval     <= req_addr;
            end else if (!req_we) begin
              lsu_wb_valid <= 1'b1;
              lsu_wb_rd    <= req_rd;
              lsu_wb_data  <= ld_data;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed bench for mem_lsu: a table of single transactions with zero-wait
// bus handshakes, plus hand sequences for bus stalls, faults, back-to-back and reset.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        cpurst_n;
  logic        mem_en, mem_wr;
  logic [31:0] mem_addr, mem_wdata;
  logic [2:0]  mem_op;
  logic [4:0]  mem_rd;
  logic        dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_be;
  logic        dbus_gnt, dbus_rvalid, dbus_err;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic        lsu_wb_valid;
  logic [4:0]  lsu_wb_rd;
  logic [31:0] lsu_wb_data;
  logic        lsu_exp;
  logic [4:0]  lsu_causecode;
  logic [31:0] lsu_mtval;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mem_lsu dut (
    .clk           (clk),
    .cpurst_n      (cpurst_n),
    .mem_en        (mem_en),
    .mem_wr        (mem_wr),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_op        (mem_op),
    .mem_rd        (mem_rd),
    .dbus_req      (dbus_req),
    .dbus_we       (dbus_we),
    .dbus_addr     (dbus_addr),
    .dbus_be       (dbus_be),
    .dbus_wdata    (dbus_wdata),
    .dbus_gnt      (dbus_gnt),
    .dbus_rvalid   (dbus_rvalid),
    .dbus_rdata    (dbus_rdata),
    .dbus_err      (dbus_err),
    .mem_stall     (mem_stall),
    .lsu_wb_valid  (lsu_wb_valid),
    .lsu_wb_rd     (lsu_wb_rd),
    .lsu_wb_data   (lsu_wb_data),
    .lsu_exp       (lsu_exp),
    .lsu_causecode (lsu_causecode),
    .lsu_mtval     (lsu_mtval)
  );

  typedef struct {
    logic        wr;
    logic [2:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic        misal;
    logic [3:0]  be;
    logic [31:0] bus_wdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic        exp;
    logic [4:0]  cause;
    logic [31:0] mtval;
  } vec_t;

  localparam int NVEC = 15;
  vec_t vecs[NVEC];

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input int i);
    vec_t v;
    v = vecs[i];
    @(posedge clk); #1;
    mem_en = 1'b1; mem_wr = v.wr; mem_op = v.op; mem_addr = v.addr;
    mem_wdata = v.wdata; mem_rd = 5'(i + 1);
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_err = 1'b0;
    @(negedge clk);
    checkOutput($sformatf("v%0d_stall_accept", i), 32'(mem_stall), 32'(!v.misal));
    checkOutput($sformatf("v%0d_req_accept", i), 32'(dbus_req), 32'd0);
    checkOutput($sformatf("v%0d_wbv_idle", i), 32'(lsu_wb_valid), 32'd0);
    checkOutput($sformatf("v%0d_exp_idle", i), 32'(lsu_exp), 32'd0);
    if (v.misal) begin
      @(posedge clk); #1;
      mem_en = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("v%0d_exp", i), 32'(lsu_exp), 32'd1);
      checkOutput($sformatf("v%0d_cause", i), 32'(lsu_causecode), 32'(v.cause));
      checkOutput($sformatf("v%0d_mtval", i), lsu_mtval, v.mtval);
      checkOutput($sformatf("v%0d_req_none", i), 32'(dbus_req), 32'd0);
      checkOutput($sformatf("v%0d_stall_none", i), 32'(mem_stall), 32'd0);
    end else begin
      @(posedge clk); #1;
      dbus_gnt = 1'b1;
      @(negedge clk);
      checkOutput($sformatf("v%0d_req", i), 32'(dbus_req), 32'd1);
      checkOutput($sformatf("v%0d_we", i), 32'(dbus_we), 32'(v.wr));
      checkOutput($sformatf("v%0d_addr", i), dbus_addr, {v.addr[31:2], 2'b00});
      checkOutput($sformatf("v%0d_be", i), 32'(dbus_be), 32'(v.be));
      if (v.wr) checkOutput($sformatf("v%0d_wdata", i), dbus_wdata, v.bus_wdata);
      checkOutput($sformatf("v%0d_stall_req", i), 32'(mem_stall), 32'd1);
      @(posedge clk); #1;
      dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = v.rdata; dbus_err = v.err;
      @(negedge clk);
      checkOutput($sformatf("v%0d_stall_rvalid", i), 32'(mem_stall), 32'd0);
      checkOutput($sformatf("v%0d_req_wait", i), 32'(dbus_req), 32'd0);
      @(posedge clk); #1;
      dbus_rvalid = 1'b0; dbus_err = 1'b0; mem_en = 1'b0;
      @(negedge clk);
      checkOutput($sformatf("v%0d_wbv", i), 32'(lsu_wb_valid), 32'(v.wb_valid));
      if (v.wb_valid) begin
        checkOutput($sformatf("v%0d_wb_data", i), lsu_wb_data, v.wb_data);
        checkOutput($sformatf("v%0d_wb_rd", i), 32'(lsu_wb_rd), 32'(i + 1));
      end
      checkOutput($sformatf("v%0d_exp", i), 32'(lsu_exp), 32'(v.exp));
      if (v.exp) begin
        checkOutput($sformatf("v%0d_cause", i), 32'(lsu_causecode), 32'(v.cause));
        checkOutput($sformatf("v%0d_mtval", i), lsu_mtval, v.mtval);
      end
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //           wr  op      addr          wdata         rdata         err misal be       bus_wdata     wbv wb_data       exp cause mtval
    vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'h0};
    vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h8012_3456, 1'b0, 1'b0, 4'b1000, 32'h0,        1'b1, 32'hFFFF_FF80, 1'b0, 5'd0, 32'h0};
    vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h8012_3456, 1'b0, 1'b0, 4'b1000, 32'h0,        1'b1, 32'h0000_0080, 1'b0, 5'd0, 32'h0};
    vecs[3]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1'b0, 1'b0, 4'b1100, 32'hABCD_ABCD, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0};
    vecs[4]  = '{1'b0, 3'b010, 32'h0000_0105, 32'h0,        32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 5'd4, 32'h0000_0105};
    vecs[5]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h8765_1234, 1'b0, 1'b0, 4'b1100, 32'h0,        1'b1, 32'hFFFF_8765, 1'b0, 5'd0, 32'h0};
    vecs[6]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h1234_9ABC, 1'b0, 1'b0, 4'b0011, 32'h0,        1'b1, 32'h0000_9ABC, 1'b0, 5'd0, 32'h0};
    vecs[7]  = '{1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0,        1'b0, 1'b0, 4'b0010, 32'hA5A5_A5A5, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0};
    vecs[8]  = '{1'b1, 3'b010, 32'h0000_03FC, 32'hCAFE_F00D, 32'h0,        1'b0, 1'b0, 4'b1111, 32'hCAFE_F00D, 1'b0, 32'h0,        1'b0, 5'd0, 32'h0};
    vecs[9]  = '{1'b1, 3'b001, 32'h0000_0203, 32'h0,        32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 5'd6, 32'h0000_0203};
    vecs[10] = '{1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 5'd4, 32'h0000_0101};
    vecs[11] = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 1'b0, 1'b0, 4'b0010, 32'h0,        1'b1, 32'h0000_007F, 1'b0, 5'd0, 32'h0};
    vecs[12] = '{1'b0, 3'b010, 32'h0000_0400, 32'h0,        32'h1111_1111, 1'b1, 1'b0, 4'b1111, 32'h0,        1'b0, 32'h0,        1'b1, 5'd5, 32'h0000_0400};
    vecs[13] = '{1'b0, 3'b011, 32'h0000_0010, 32'h0,        32'h1122_3344, 1'b0, 1'b0, 4'b1111, 32'h0,        1'b1, 32'h1122_3344, 1'b0, 5'd0, 32'h0};
    vecs[14] = '{1'b1, 3'b111, 32'h0000_0012, 32'h0,        32'h0,        1'b0, 1'b1, 4'b0000, 32'h0,        1'b0, 32'h0,        1'b1, 5'd6, 32'h0000_0012};

    cpurst_n = 1'b0;
    mem_en = 1'b0; mem_wr = 1'b0; mem_addr = '0; mem_wdata = '0; mem_op = '0; mem_rd = '0;
    dbus_gnt = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = '0; dbus_err = 1'b0;
    #3;
    checkOutput("rst_req", 32'(dbus_req), 32'd0);
    checkOutput("rst_stall", 32'(mem_stall), 32'd0);
    checkOutput("rst_wbv", 32'(lsu_wb_valid), 32'd0);
    checkOutput("rst_exp", 32'(lsu_exp), 32'd0);
    checkOutput("rst_be", 32'(dbus_be), 32'd0);
    #9 cpurst_n = 1'b1;

    for (int i = 0; i < NVEC; i++) applyStimulus(i);

    // Store with grant held off for three cycles, then an error response
    @(posedge clk); #1;
    mem_en = 1'b1; mem_wr = 1'b1; mem_op = 3'b010; mem_addr = 32'h500; mem_wdata = 32'h55AA_55AA; mem_rd = 5'd0;
    @(negedge clk);
    checkOutput("flt_stall_accept", 32'(mem_stall), 32'd1);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput($sformatf("flt_req_hold%0d", k), 32'(dbus_req), 32'd1);
      checkOutput($sformatf("flt_addr_hold%0d", k), dbus_addr, 32'h500);
      checkOutput($sformatf("flt_wdata_hold%0d", k), dbus_wdata, 32'h55AA_55AA);
      checkOutput($sformatf("flt_be_hold%0d", k), 32'(dbus_be), 32'hF);
    end
    @(posedge clk); #1 dbus_gnt = 1'b1;
    @(negedge clk);
    checkOutput("flt_req_gnt", 32'(dbus_req), 32'd1);
    @(posedge clk); #1 dbus_gnt = 1'b0;
    @(negedge clk);
    checkOutput("flt_req_wait", 32'(dbus_req), 32'd0);
    checkOutput("flt_stall_wait", 32'(mem_stall), 32'd1);
    @(posedge clk); #1 dbus_rvalid = 1'b1; dbus_err = 1'b1;
    @(negedge clk);
    checkOutput("flt_stall_rvalid", 32'(mem_stall), 32'd0);
    @(posedge clk); #1 dbus_rvalid = 1'b0; dbus_err = 1'b0; mem_en = 1'b0;
    @(negedge clk);
    checkOutput("flt_exp", 32'(lsu_exp), 32'd1);
    checkOutput("flt_cause", 32'(lsu_causecode), 32'd7);
    checkOutput("flt_mtval", lsu_mtval, 32'h500);
    checkOutput("flt_wbv", 32'(lsu_wb_valid), 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("flt_exp_pulse", 32'(lsu_exp), 32'd0);

    // Back-to-back: second load presented in the cycle after rvalid
    @(posedge clk); #1;
    mem_en = 1'b1; mem_wr = 1'b0; mem_op = 3'b100; mem_addr = 32'h702; mem_rd = 5'd7;
    @(posedge clk); #1 dbus_gnt = 1'b1;
    @(posedge clk); #1 dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h00C3_0000;
    @(negedge clk);
    checkOutput("b2b_stall_rvalid", 32'(mem_stall), 32'd0);
    @(posedge clk); #1;
    dbus_rvalid = 1'b0; mem_op = 3'b010; mem_addr = 32'h704; mem_rd = 5'd8;
    @(negedge clk);
    checkOutput("b2b_wbv1", 32'(lsu_wb_valid), 32'd1);
    checkOutput("b2b_data1", lsu_wb_data, 32'h0000_00C3);
    checkOutput("b2b_rd1", 32'(lsu_wb_rd), 32'd7);
    checkOutput("b2b_stall_accept2", 32'(mem_stall), 32'd1);
    @(posedge clk); #1 dbus_gnt = 1'b1;
    @(negedge clk);
    checkOutput("b2b_req2", 32'(dbus_req), 32'd1);
    checkOutput("b2b_addr2", dbus_addr, 32'h704);
    @(posedge clk); #1 dbus_gnt = 1'b0; dbus_rvalid = 1'b1; dbus_rdata = 32'h0BAD_F00D;
    @(posedge clk); #1 dbus_rvalid = 1'b0; mem_en = 1'b0;
    @(negedge clk);
    checkOutput("b2b_wbv2", 32'(lsu_wb_valid), 32'd1);
    checkOutput("b2b_data2", lsu_wb_data, 32'h0BAD_F00D);
    checkOutput("b2b_rd2", 32'(lsu_wb_rd), 32'd8);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("b2b_wbv_pulse", 32'(lsu_wb_valid), 32'd0);
    checkOutput("b2b_req_none", 32'(dbus_req), 32'd0);

    // Reset while waiting for the response
    @(posedge clk); #1;
    mem_en = 1'b1; mem_wr = 1'b0; mem_op = 3'b001; mem_addr = 32'h602; mem_rd = 5'd3;
    @(posedge clk); #1 dbus_gnt = 1'b1;
    @(posedge clk); #1 dbus_gnt = 1'b0;
    @(negedge clk);
    checkOutput("rstw_stall_wait", 32'(mem_stall), 32'd1);
    #1 cpurst_n = 1'b0; mem_en = 1'b0;
    #1;
    checkOutput("rstw_stall", 32'(mem_stall), 32'd0);
    checkOutput("rstw_be", 32'(dbus_be), 32'd0);
    checkOutput("rstw_addr", dbus_addr, 32'd0);
    checkOutput("rstw_wb_data", lsu_wb_data, 32'd0);
    checkOutput("rstw_wb_rd", 32'(lsu_wb_rd), 32'd0);
    checkOutput("rstw_mtval", lsu_mtval, 32'd0);
    #1 cpurst_n = 1'b1;

    // Reset while requesting: the request must drop without a clock edge
    @(posedge clk); #1;
    mem_en = 1'b1; mem_op = 3'b010; mem_addr = 32'h608;
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("rstq_req_before", 32'(dbus_req), 32'd1);
    #1 cpurst_n = 1'b0; mem_en = 1'b0;
    #1;
    checkOutput("rstq_req_after", 32'(dbus_req), 32'd0);
    checkOutput("rstq_stall_after", 32'(mem_stall), 32'd0);
    #1 cpurst_n = 1'b1;

    // Stale response after reset must be ignored
    @(posedge clk); #1 dbus_rvalid = 1'b1; dbus_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    checkOutput("stale_stall", 32'(mem_stall), 32'd0);
    @(posedge clk); #1 dbus_rvalid = 1'b0;
    @(negedge clk);
    checkOutput("stale_wbv", 32'(lsu_wb_valid), 32'd0);
    checkOutput("stale_exp", 32'(lsu_exp), 32'd0);
    checkOutput("stale_req", 32'(dbus_req), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_lsu.md
# mem_lsu

Memory-stage load/store unit: the consumer of the EX/MEM pipeline register's memory fields. It turns a registered memory request (address, op, store data, destination register) into a single outstanding transaction on the data bus, generates `mem_stall` back to the pipeline registers while the transaction is in flight, and returns aligned, sign/zero-extended load data plus misalignment and access-fault exceptions to write-back.

## Interface
- No parameters (XLEN fixed at 32).
- `clk` in 1: core clock, all state on rising edge.
- `cpurst_n` in 1: reset, asynchronous, active-low.
- `mem_en` in 1: memory instruction present this cycle (held stable while `mem_stall`=1).
- `mem_wr` in 1: 1 = store, 0 = load.
- `mem_addr` in 32: byte address.
- `mem_wdata` in 32: store data, right-justified.
- `mem_op` in 3: funct3 — 000 B, 001 H, 010 W, 100 BU, 101 HU; others are illegal and treated as W.
- `mem_rd` in 5: load destination index.
- `dbus_req` out 1; `dbus_we` out 1; `dbus_addr` out 32 (word aligned); `dbus_be` out 4; `dbus_wdata` out 32.
- `dbus_gnt` in 1: request accepted.
- `dbus_rvalid` in 1: response, for loads and stores.
- `dbus_rdata` in 32.
- `dbus_err` in 1: qualifies `dbus_rvalid`.
- `mem_stall` out 1: holds upstream pipeline registers.
- `lsu_wb_valid` out 1; `lsu_wb_rd` out 5; `lsu_wb_data` out 32: load write-back.
- `lsu_exp` out 1; `lsu_causecode` out 5; `lsu_mtval` out 32: exception report.

## Operation
- FSM states are IDLE, REQ and WAIT.
- **IDLE**
  - `mem_en`=1 and misaligned: one-cycle `lsu_exp` on the next cycle and no bus activity. Misaligned means H/HU with `addr[0]`=1, or W with `addr[1:0]`≠0. Cause is 4 for a load and 6 for a store; `mtval` = `mem_addr`.
  - `mem_en`=1 and aligned: latch the request, go to REQ.
- **REQ**
  - `dbus_req`=1 with latched `we`/`addr`/`be`/`wdata`, held constant until `dbus_gnt`.
  - On gnt, go to WAIT.
- **WAIT**
  - `dbus_req`=0. On `dbus_rvalid`, go to IDLE.
  - On error: fault with cause 5 (load) or 7 (store); `mtval` = latched address; no write-back.
  - On success for a load: capture the extracted data, `lsu_wb_valid`=1 next cycle.
  - On success for a store: no write-back.
- **Store lanes**
  - B replicates the byte to all 4 lanes with `be` = 1<<`addr[1:0]`.
  - H replicates the half to both halves with `be` = 0011 or 1100.
  - W uses `be` = 1111.
- **Load extract**
  - B/BU select the byte at `addr[1:0]`; H/HU select the half at `addr[1]`.
  - B and H sign-extend; BU and HU zero-extend.
- **`mem_stall`** is combinational: (IDLE & `mem_en` & aligned) | REQ | (WAIT & !`dbus_rvalid`).
  - It deasserts in the rvalid cycle, so the upstream register advances on that edge. This prevents double issue.
- **Reset values:** all outputs 0, state IDLE.
- **Reset mid-transaction:** `dbus_req` drops asynchronously and any later `rvalid` is ignored (the bus is reset by the same signal).

## Timing
- Minimum load latency: accept (cycle 0), REQ with gnt (1), rvalid (2), `lsu_wb_valid` (3). Stall is high in cycles 0–1 and low in cycle 2.
- `gnt` and `rvalid` may stall indefinitely. `rvalid` never coincides with gnt of the same transaction.
- One outstanding transaction at a time; no pipelining of requests.
- `lsu_wb_*` and `lsu_exp`/`cause`/`mtval` are registered, one-cycle pulses. Data and index are held until the next pulse.
- Back-to-back: a new `mem_en` in the cycle after rvalid is accepted in IDLE immediately.

## Structure
- Package `lsu_pkg` holds:
  - the `mem_op` encodings (`LSU_OP_B`, `LSU_OP_H`, `LSU_OP_W`, `LSU_OP_BU`, `LSU_OP_HU`);
  - the cause codes (`CAUSE_LD_MISALIGN`=4, `CAUSE_LD_FAULT`=5, `CAUSE_ST_MISALIGN`=6, `CAUSE_ST_FAULT`=7);
  - the FSM state encoding.
- Sub-module `lsu_align` (combinational) performs the store lane/byte-enable generation and the load extract/extension. The FSM and registers stay in `mem_lsu`.

## Test plan
- **LW, no bus wait:** LW at 0x100, `gnt` immediate, `rvalid` next cycle with data 0xDEADBEEF -> `dbus_be`=1111, `mem_stall` high 2 cycles, `lsu_wb_data`=0xDEADBEEF.
- **Byte loads:** LB at 0x103 with rdata 0x80xxxxxx -> `wb_data`=0xFFFFFF80. LBU on the same access -> 0x00000080.
- **SH:** SH at 0x202 with wdata 0x1234ABCD -> `dbus_wdata`=0xABCDABCD, `be`=1100, `we`=1, no `wb_valid`.
- **Misaligned LW:** LW at 0x105 -> no `dbus_req`, `mem_stall`=0, `lsu_exp`=1, cause=4, `mtval`=0x105.
- **Access fault:** SW, `gnt` delayed 3 cycles, then `rvalid` with `dbus_err`=1 -> `req` stable for 3 cycles, cause=7, `mtval`=address, no write-back.
- **Reset mid-transaction:** `cpurst_n` asserted while in WAIT -> all outputs 0 immediately; a later stale `rvalid` produces no `wb_valid`.
